// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request side and instruction-memory write side of inst_encoder.
interface inst_encoder_if;
    logic        flush;
    logic        enc_valid;
    logic        enc_ready;
    logic [3:0]  enc_sel;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic        rom_we;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ack;
    logic [15:0] wr_count;
    logic        enc_err;
    modport master (
        output flush, enc_valid, enc_sel, rs, rt, rd, sa, imm, rom_ack,
        input  enc_ready, rom_we, rom_addr, rom_data, wr_count, enc_err
    );
    modport slave (
        input  flush, enc_valid, enc_sel, rs, rt, rd, sa, imm, rom_ack,
        output enc_ready, rom_we, rom_addr, rom_data, wr_count, enc_err
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: encodes MIPS instruction requests, buffers them and writes them to instruction memory.
// Define ENC_ZERO_DST_CHECK_EN to reject requests whose destination register is $0.
module inst_encoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input logic           clk,
    input logic           rst,
    inst_encoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t        state, state_nxt;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic [31:0]   word, addr;
    logic [15:0]   count;
    logic          full, empty, accept, reject, push, pop;
    assign full          = cnt == (AW+1)'(FIFO_DEPTH);
    assign empty         = cnt == '0;
    assign bus.enc_ready = rst & ~bus.flush & ~full;
    assign accept        = bus.enc_valid & bus.enc_ready;
    assign push          = accept & ~reject;
    // flush abandons a write in progress, so its ack must not pop
    assign pop           = (state == WRITE) & bus.rom_ack & ~bus.flush;
`ifdef ENC_ZERO_DST_CHECK_EN
    logic err;
    // rd is the destination for R-type and fixed shifts, rt for the immediate forms; SYNC/PREF exempt
    assign reject = (bus.enc_sel <= 4'd6 || bus.enc_sel >= 4'd13) ? bus.rd == 5'd0 :
                    (bus.enc_sel >= 4'd8 && bus.enc_sel <= 4'd11) ? bus.rt == 5'd0 : 1'b0;
    always_ff @(posedge clk) begin
        if (!rst) err <= 1'b0;
        else err <= accept & reject;
    end
    assign bus.enc_err = err;
`else
    assign reject      = 1'b0;
    assign bus.enc_err = 1'b0;
`endif
    always_comb begin
        word = 32'h0;
        case (bus.enc_sel)
            4'd0:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h0, 6'h25};
            4'd1:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h0, 6'h24};
            4'd2:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h0, 6'h26};
            4'd3:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h0, 6'h27};
            4'd4:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h0, 6'h04};
            4'd5:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h0, 6'h06};
            4'd6:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h0, 6'h07};
            4'd7:  word = {21'h0, bus.sa, 6'h0F};
            4'd8:  word = {6'h0D, bus.rs, bus.rt, bus.imm};
            4'd9:  word = {6'h0C, bus.rs, bus.rt, bus.imm};
            4'd10: word = {6'h0E, bus.rs, bus.rt, bus.imm};
            4'd11: word = {6'h0F, 5'h0, bus.rt, bus.imm};
            4'd12: word = {6'h33, bus.rs, bus.rt, bus.imm};
            4'd13: word = {11'h0, bus.rt, bus.rd, bus.sa, 6'h00};
            4'd14: word = {11'h0, bus.rt, bus.rd, bus.sa, 6'h02};
            4'd15: word = {11'h0, bus.rt, bus.rd, bus.sa, 6'h03};
        endcase
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end
    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            addr   <= BASE_ADDR;
            count  <= 16'h0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                addr   <= addr + 32'd4;
                count  <= count + 16'd1;
            end
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst || bus.flush) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (empty ? IDLE : WRITE) :
                    ((bus.rom_ack && cnt == (AW+1)'(1)) ? IDLE : WRITE);
    end
    // head word is stable while unacked: a full FIFO never overwrites the head slot
    always_comb begin
        bus.rom_we   = state == WRITE;
        bus.rom_data = (state == WRITE) ? mem[rd_ptr] : 32'h0;
        bus.rom_addr = addr;
        bus.wr_count = count;
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed self-checking bench for inst_encoder.
module tb_inst_encoder;
    logic clk, rst;
    int checks, failures;
    inst_encoder_if bus ();
    inst_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [3:0] sel, input logic [4:0] rs, rt, rd, sa, input logic [15:0] imm);
        bus.enc_sel = sel; bus.rs = rs; bus.rt = rt; bus.rd = rd; bus.sa = sa; bus.imm = imm;
        bus.enc_valid = 1'b1;
        step();
        bus.enc_valid = 1'b0;
    endtask
    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (bus.rom_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", bus.rom_we); end
        checks++; if (bus.rom_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.rom_addr); end
        checks++; if (bus.rom_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.rom_data); end
        checks++; if (bus.wr_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%0h exp=0", bus.wr_count); end
        checks++; if (bus.enc_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.enc_err); end
        checks++; if (bus.enc_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0h exp=0", bus.enc_ready); end
        rst = 1'b1;
        step();
        checks++; if (bus.enc_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%0h exp=1", bus.enc_ready); end
    endtask
    task automatic test_ori();
        bus.rom_ack = 1'b1;
        send(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234);
        for (int i = 0; i < 20 && !bus.rom_we; i++) step();
        checks++; if (bus.rom_we !== 1'b1) begin failures++; $display("FAIL ori_we got=%0h exp=1", bus.rom_we); end
        checks++; if (bus.rom_addr !== 32'h0) begin failures++; $display("FAIL ori_addr got=%0h exp=0", bus.rom_addr); end
        checks++; if (bus.rom_data !== 32'h34221234) begin failures++; $display("FAIL ori_data got=%0h exp=34221234", bus.rom_data); end
        step();
        checks++; if (bus.wr_count !== 16'd1) begin failures++; $display("FAIL ori_count got=%0h exp=1", bus.wr_count); end
        checks++; if (bus.rom_we !== 1'b0) begin failures++; $display("FAIL ori_we_low got=%0h exp=0", bus.rom_we); end
        bus.rom_ack = 1'b0;
    endtask
    task automatic test_back_to_back();
        do_flush();
        bus.rom_ack = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        send(4'd13, 5'd0, 5'd1, 5'd2, 5'd4, 16'h0);
        for (int i = 0; i < 20 && !bus.rom_we; i++) step();
        step();
        checks++; if (bus.rom_addr !== 32'h0) begin failures++; $display("FAIL b2b_addr0 got=%0h exp=0", bus.rom_addr); end
        checks++; if (bus.rom_data !== 32'h00221825) begin failures++; $display("FAIL b2b_data0 got=%0h exp=00221825", bus.rom_data); end
        bus.rom_ack = 1'b1;
        step();
        checks++; if (bus.rom_we !== 1'b1) begin failures++; $display("FAIL b2b_we1 got=%0h exp=1", bus.rom_we); end
        checks++; if (bus.rom_addr !== 32'h4) begin failures++; $display("FAIL b2b_addr1 got=%0h exp=4", bus.rom_addr); end
        checks++; if (bus.rom_data !== 32'h00011100) begin failures++; $display("FAIL b2b_data1 got=%0h exp=00011100", bus.rom_data); end
        step();
        bus.rom_ack = 1'b0;
        checks++; if (bus.wr_count !== 16'd2) begin failures++; $display("FAIL b2b_count got=%0h exp=2", bus.wr_count); end
    endtask
    task automatic test_lui();
        do_flush();
        bus.rom_ack = 1'b1;
        send(4'd11, 5'd7, 5'd1, 5'd0, 5'd0, 16'h8000);
        for (int i = 0; i < 20 && !bus.rom_we; i++) step();
        checks++; if (bus.rom_data !== 32'h3C018000) begin failures++; $display("FAIL lui_data got=%0h exp=3C018000", bus.rom_data); end
        step();
        bus.rom_ack = 1'b0;
    endtask
    task automatic test_classes();
        logic [3:0]  sel [10] = '{4'd1, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12, 4'd14, 4'd15};
        logic [4:0]  rs  [10] = '{5'd4, 5'd1, 5'd1, 5'd3, 5'd3, 5'd31, 5'd0, 5'd2, 5'd31, 5'd0};
        logic [4:0]  rt  [10] = '{5'd5, 5'd2, 5'd2, 5'd4, 5'd3, 5'd1, 5'd7, 5'd0, 5'd1, 5'd3};
        logic [4:0]  rd  [10] = '{5'd6, 5'd3, 5'd3, 5'd5, 5'd3, 5'd0, 5'd0, 5'd0, 5'd2, 5'd4};
        logic [4:0]  sa  [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd1, 5'd31};
        logic [15:0] imm [10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h00FF, 16'h0010, 16'h0, 16'h0};
        logic [31:0] exp [10] = '{32'h00853024, 32'h00221827, 32'h00221806, 32'h00642807, 32'h0000014F,
                                  32'h33E1FFFF, 32'h380700FF, 32'hCC400010, 32'h00011042, 32'h000327C3};
        do_flush();
        bus.rom_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send(sel[k], rs[k], rt[k], rd[k], sa[k], imm[k]);
            for (int i = 0; i < 20 && !bus.rom_we; i++) step();
            checks++; if (bus.rom_data !== exp[k]) begin failures++; $display("FAIL class%0d_data got=%0h exp=%0h", sel[k], bus.rom_data, exp[k]); end
            checks++; if (bus.rom_addr !== 32'(k * 4)) begin failures++; $display("FAIL class%0d_addr got=%0h exp=%0h", sel[k], bus.rom_addr, k * 4); end
            step();
        end
        bus.rom_ack = 1'b0;
    endtask
    task automatic test_full();
        logic [31:0] got_addr [5];
        logic [31:0] got_data [5];
        int n;
        logic acc;
        do_flush();
        bus.rom_ack = 1'b0;
        for (int k = 0; k < 4; k++) send(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'(k));
        checks++; if (bus.enc_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0h exp=0", bus.enc_ready); end
        bus.enc_sel = 4'd8; bus.imm = 16'd4; bus.enc_valid = 1'b1;
        step();
        bus.rom_ack = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            if (bus.rom_we) begin
                got_addr[n] = bus.rom_addr;
                got_data[n] = bus.rom_data;
                n++;
            end
            acc = bus.enc_valid & bus.enc_ready;
            step();
            if (acc) bus.enc_valid = 1'b0;
        end
        bus.enc_valid = 1'b0;
        bus.rom_ack = 1'b0;
        checks++; if (n !== 5) begin failures++; $display("FAIL full_writes got=%0d exp=5", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (got_addr[k] !== 32'(k * 4)) begin failures++; $display("FAIL full_addr%0d got=%0h exp=%0h", k, got_addr[k], k * 4); end
            checks++; if (got_data[k] !== (32'h34220000 | 32'(k))) begin failures++; $display("FAIL full_data%0d got=%0h exp=%0h", k, got_data[k], 32'h34220000 | 32'(k)); end
        end
        step();
        checks++; if (bus.wr_count !== 16'd5) begin failures++; $display("FAIL full_count got=%0h exp=5", bus.wr_count); end
        checks++; if (bus.rom_we !== 1'b0) begin failures++; $display("FAIL full_we_low got=%0h exp=0", bus.rom_we); end
    endtask
    task automatic test_flush();
        do_flush();
        bus.rom_ack = 1'b0;
        for (int k = 0; k < 3; k++) send(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'hA + 16'(k));
        for (int i = 0; i < 20 && !bus.rom_we; i++) step();
        checks++; if (bus.rom_we !== 1'b1) begin failures++; $display("FAIL flush_pre_we got=%0h exp=1", bus.rom_we); end
        bus.flush = 1'b1;
        bus.rom_ack = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.rom_ack = 1'b0;
        checks++; if (bus.rom_we !== 1'b0) begin failures++; $display("FAIL flush_we got=%0h exp=0", bus.rom_we); end
        checks++; if (bus.wr_count !== 16'd0) begin failures++; $display("FAIL flush_count got=%0h exp=0", bus.wr_count); end
        checks++; if (bus.rom_addr !== 32'h0) begin failures++; $display("FAIL flush_addr got=%0h exp=0", bus.rom_addr); end
        step();
        checks++; if (bus.rom_we !== 1'b0) begin failures++; $display("FAIL flush_empty_we got=%0h exp=0", bus.rom_we); end
        bus.rom_ack = 1'b1;
        send(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234);
        for (int i = 0; i < 20 && !bus.rom_we; i++) step();
        checks++; if (bus.rom_addr !== 32'h0) begin failures++; $display("FAIL flush_new_addr got=%0h exp=0", bus.rom_addr); end
        checks++; if (bus.rom_data !== 32'h34221234) begin failures++; $display("FAIL flush_new_data got=%0h exp=34221234", bus.rom_data); end
        step();
        checks++; if (bus.wr_count !== 16'd1) begin failures++; $display("FAIL flush_new_count got=%0h exp=1", bus.wr_count); end
        bus.rom_ack = 1'b0;
    endtask
    task automatic test_zero_dst();
        do_flush();
        bus.rom_ack = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0);
`ifdef ENC_ZERO_DST_CHECK_EN
        checks++; if (bus.enc_err !== 1'b1) begin failures++; $display("FAIL zero_err got=%0h exp=1", bus.enc_err); end
        step();
        checks++; if (bus.enc_err !== 1'b0) begin failures++; $display("FAIL zero_err_pulse got=%0h exp=0", bus.enc_err); end
        repeat (4) step();
        checks++; if (bus.wr_count !== 16'd0) begin failures++; $display("FAIL zero_count got=%0h exp=0", bus.wr_count); end
`else
        checks++; if (bus.enc_err !== 1'b0) begin failures++; $display("FAIL zero_err got=%0h exp=0", bus.enc_err); end
        for (int i = 0; i < 20 && !bus.rom_we; i++) step();
        checks++; if (bus.rom_addr !== 32'h0) begin failures++; $display("FAIL zero_addr got=%0h exp=0", bus.rom_addr); end
        checks++; if (bus.rom_data !== 32'h00220025) begin failures++; $display("FAIL zero_data got=%0h exp=00220025", bus.rom_data); end
        step();
`endif
        bus.rom_ack = 1'b0;
    endtask
    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.flush = 1'b0; bus.enc_valid = 1'b0; bus.enc_sel = 4'd0;
        bus.rs = 5'd0; bus.rt = 5'd0; bus.rd = 5'd0; bus.sa = 5'd0; bus.imm = 16'h0;
        bus.rom_ack = 1'b0;
        test_reset();
        test_ori();
        test_back_to_back();
        test_lui();
        test_classes();
        test_full();
        test_flush();
        test_zero_dst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
